// File: rtl/code_entry_ctrl.sv
// Number-lock keypad stage: 6-digit entry buffer, password compare, open/error/lockout FSM, 7-seg image.
// Build option MASK_ENTRY_EN: entered digits are displayed as '-' instead of their values.
module code_entry_ctrl #(
  parameter logic [23:0] PASSWORD    = 24'h123456,
  parameter int unsigned OPEN_CYCLES = 150000000,
  parameter int unsigned ERR_CYCLES  = 50000000,
  parameter int unsigned LOCK_CYCLES = 500000000,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] seg_data_0,
  output logic [6:0] seg_data_1,
  output logic [6:0] seg_data_2,
  output logic [6:0] seg_data_3,
  output logic [6:0] seg_data_4,
  output logic [6:0] seg_data_5,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] fail_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ENTRY, ST_CHECK, ST_OPEN, ST_ERROR, ST_LOCKOUT
  } state_t;

  localparam logic [3:0]  KEY_CLEAR  = 4'hA;
  localparam logic [3:0]  KEY_BACK   = 4'hB;
  localparam logic [3:0]  KEY_ENTER  = 4'hE;
  localparam logic [31:0] OPEN_LAST  = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] ERR_LAST   = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST  = 32'(LOCK_CYCLES - 1);
  localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);

  // Active-low segments, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_R     = 7'h2F;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h40;
      4'd1:    seg_digit = 7'h79;
      4'd2:    seg_digit = 7'h24;
      4'd3:    seg_digit = 7'h30;
      4'd4:    seg_digit = 7'h19;
      4'd5:    seg_digit = 7'h12;
      4'd6:    seg_digit = 7'h02;
      4'd7:    seg_digit = 7'h78;
      4'd8:    seg_digit = 7'h00;
      4'd9:    seg_digit = 7'h10;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [23:0] buffer_q, buffer_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  fail_d, fail_inc;
  logic [31:0] timer_q, timer_d;
  logic        match_q, match_d;
  logic        fail_event;
  logic [6:0]  seg_q [6];
  logic [6:0]  seg_d [6];
  logic [6:0]  digit_seg;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    buffer_d   = buffer_q;
    count_d    = count_q;
    fail_d     = fail_cnt;
    timer_d    = timer_q;
    match_d    = match_q;
    fail_event = 1'b0;
    fail_inc   = fail_cnt + 3'd1;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (count_q < 3'd6) begin
              buffer_d = {buffer_q[19:0], key_code};
              count_d  = count_q + 3'd1;
              state_d  = ST_ENTRY;
            end
          end else if (key_code == KEY_BACK) begin
            if (count_q != 3'd0) begin
              buffer_d = buffer_q >> 4;
              count_d  = count_q - 3'd1;
              if (count_q == 3'd1) state_d = ST_IDLE;
            end
          end else if (key_code == KEY_CLEAR) begin
            buffer_d = '0;
            count_d  = '0;
            state_d  = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            if (count_q == 3'd6) begin
              match_d = (buffer_q == PASSWORD);
              state_d = ST_CHECK;
            end else begin
              fail_event = 1'b1;
            end
          end
        end
      end
      ST_CHECK: begin
        if (match_q) begin
          fail_d  = '0;
          timer_d = '0;
          state_d = ST_OPEN;
        end else begin
          fail_event = 1'b1;
        end
      end
      ST_OPEN: begin
        if ((key_valid && key_code == KEY_CLEAR) || timer_q == OPEN_LAST) begin
          buffer_d = '0;
          count_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_ERROR: begin
        if (timer_q == ERR_LAST) state_d = ST_IDLE;
        else                     timer_d = timer_q + 32'd1;
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Short entry and code mismatch share one failure path.
    if (fail_event) begin
      fail_d   = fail_inc;
      buffer_d = '0;
      count_d  = '0;
      timer_d  = '0;
      state_d  = (fail_inc == FAIL_LIMIT) ? ST_LOCKOUT : ST_ERROR;
    end
  end

  always_comb begin
    digit_seg = SEG_BLANK;
    for (int i = 0; i < 6; i++) seg_d[i] = SEG_BLANK;
    case (state_q)
      ST_ENTRY, ST_CHECK: begin
        for (int i = 0; i < 6; i++) begin
`ifdef MASK_ENTRY_EN
          digit_seg = SEG_DASH;
`else
          digit_seg = seg_digit(buffer_q[4*i +: 4]);
`endif
          if (i < int'(count_q)) seg_d[i] = digit_seg;
        end
      end
      ST_OPEN: begin
        seg_d[3] = SEG_O;
        seg_d[2] = SEG_P;
        seg_d[1] = SEG_E;
        seg_d[0] = SEG_N;
      end
      ST_ERROR: begin
        seg_d[2] = SEG_E;
        seg_d[1] = SEG_R;
        seg_d[0] = SEG_R;
      end
      ST_LOCKOUT: begin
        for (int i = 0; i < 6; i++) seg_d[i] = SEG_DASH;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      buffer_q <= '0;
      count_q  <= '0;
      fail_cnt <= '0;
      timer_q  <= '0;
      match_q  <= 1'b0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      // NOTE: the display array is six flops, not a RAM, so it is reset to a known blank image.
      for (int i = 0; i < 6; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      fail_cnt <= fail_d;
      timer_q  <= timer_d;
      match_q  <= match_d;
      unlocked <= (state_q == ST_OPEN);
      alarm    <= (state_q == ST_LOCKOUT);
      for (int i = 0; i < 6; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign seg_data_0 = seg_q[0];
  assign seg_data_1 = seg_q[1];
  assign seg_data_2 = seg_q[2];
  assign seg_data_3 = seg_q[3];
  assign seg_data_4 = seg_q[4];
  assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboard bench for code_entry_ctrl with short timers (OPEN 20, ERROR 10, LOCKOUT 30, MAX_FAIL 3).
module tb_code_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [6:0] seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5;
  logic       unlocked, alarm;
  logic [2:0] fail_cnt;

  code_entry_ctrl #(
    .PASSWORD   (24'h123456),
    .OPEN_CYCLES(20),
    .ERR_CYCLES (10),
    .LOCK_CYCLES(30),
    .MAX_FAIL   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .seg_data_0(seg_data_0),
    .seg_data_1(seg_data_1),
    .seg_data_2(seg_data_2),
    .seg_data_3(seg_data_3),
    .seg_data_4(seg_data_4),
    .seg_data_5(seg_data_5),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0]  B = 7'h7F;
  localparam logic [6:0]  D = 7'h3F;
  localparam logic [6:0]  DSEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [41:0] ALL_B    = {6{7'h7F}};
  localparam logic [41:0] ALL_D    = {6{7'h3F}};
  localparam logic [41:0] OPEN_IMG = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
  localparam logic [41:0] ERR_IMG  = {7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F};

  typedef struct {
    string       name;
    logic [46:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   ent[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [46:0] outs();
    return {seg_data_5, seg_data_4, seg_data_3, seg_data_2, seg_data_1, seg_data_0,
            unlocked, alarm, fail_cnt};
  endfunction

  function automatic logic [46:0] pk(input logic [41:0] seg, input logic u, input logic a,
                                     input logic [2:0] f);
    return {seg, u, a, f};
  endfunction

  // Expected display for the digits currently held (newest at position 0).
  function automatic logic [41:0] entry_img();
    logic [6:0] s [6];
    for (int j = 0; j < 6; j++) begin
      s[j] = B;
      if (j < ent.size()) begin
`ifdef MASK_ENTRY_EN
        s[j] = D;
`else
        s[j] = DSEG[ent[ent.size() - 1 - j]];
`endif
      end
    end
    return {s[5], s[4], s[3], s[2], s[1], s[0]};
  endfunction

  task automatic push_exp(input string n, input logic [46:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  // Called at a falling edge; key is sampled on the next rising edge.
  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_code(input logic [23:0] code);
    for (int i = 0; i < 6; i++) key(code[23 - 4*i -: 4]);
    key(4'hE);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ent.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    push_exp("reset_held", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    rst_n = 1'b1;
    @(negedge clk);
    push_exp("reset_released", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
  endtask

  task automatic test_open();
    for (int d = 1; d <= 6; d++) begin
      key(4'(d));
      ent.push_back(d);
      @(negedge clk);
      push_exp($sformatf("open_digit%0d", d), pk(entry_img(), 1'b0, 1'b0, 3'd0));
      e = sb.pop_front(); checks++;
      if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    end
    key(4'hE);
    // Edge E+1 shows the CHECK cycle, E+2..E+21 the OPEN image, E+22 idle.
    push_exp("open_check_cycle", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    for (int k = 2; k <= 21; k++) push_exp($sformatf("open_c%0d", k), pk(OPEN_IMG, 1'b1, 1'b0, 3'd0));
    push_exp("open_relock", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    end
    ent.delete();
  endtask

  task automatic test_edit();
    for (int d = 1; d <= 3; d++) begin key(4'(d)); ent.push_back(d); end
    @(negedge clk);
    push_exp("edit_123", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hB);
    void'(ent.pop_back());
    @(negedge clk);
    push_exp("edit_backspace", pk({B, B, B, B, 7'h79, 7'h24}, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hA);
    ent.delete();
    @(negedge clk);
    push_exp("edit_clear", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hB);
    key(4'hC);
    key(4'hF);
    @(negedge clk);
    push_exp("edit_idle_ignored", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'h4);
    key(4'hB);
    key(4'h5);
    ent.push_back(5);
    @(negedge clk);
    push_exp("edit_back_to_one", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hA);
    ent.delete();
  endtask

  task automatic test_overflow();
    for (int d = 1; d <= 7; d++) key(4'(d));
    for (int d = 1; d <= 6; d++) ent.push_back(d);
    @(negedge clk);
    push_exp("overflow_7th_ignored", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hA);
    ent.delete();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    key_valid = 1'b1;
    key_code  = 4'h7;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) ent.push_back(7);
    @(negedge clk);
    push_exp("held_key_three_events", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hA);
    ent.delete();
    @(negedge clk);
  endtask

  task automatic test_short_enter();
    key(4'h1);
    ent.push_back(1);
    @(negedge clk);
    key(4'hE);
    push_exp("short_enter_fail_cnt", pk(entry_img(), 1'b0, 1'b0, 3'd1));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    ent.delete();
    @(negedge clk);
    push_exp("short_enter_err", pk(ERR_IMG, 1'b0, 1'b0, 3'd1));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'h5);
    repeat (8) @(negedge clk);
    push_exp("error_last_cycle", pk(ERR_IMG, 1'b0, 1'b0, 3'd1));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    @(negedge clk);
    push_exp("error_timeout_idle", pk(ALL_B, 1'b0, 1'b0, 3'd1));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int f = 1; f <= 2; f++) begin
      enter_code(24'h654321);
      repeat (12) @(negedge clk);
      push_exp($sformatf("lockout_prefail%0d", f), pk(ALL_B, 1'b0, 1'b0, 3'(f)));
      e = sb.pop_front(); checks++;
      if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    end
    enter_code(24'h654321);
    ent = '{6, 5, 4, 3, 2, 1};
    push_exp("lockout_enter", pk(entry_img(), 1'b0, 1'b0, 3'd2));
    push_exp("lockout_check", pk(entry_img(), 1'b0, 1'b0, 3'd3));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    ent.delete();
    // Keys of every code are thrown at the lock while it is alarmed.
    for (int k = 2; k <= 31; k++) begin
      @(negedge clk);
      push_exp($sformatf("lockout_c%0d", k), pk(ALL_D, 1'b0, 1'b1, (k == 31) ? 3'd0 : 3'd3));
      e = sb.pop_front(); checks++;
      if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
      key_valid = (k < 31);
      key_code  = 4'(k % 16);
    end
    key_valid = 1'b0;
    @(negedge clk);
    push_exp("lockout_released", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
  endtask

  task automatic test_fail_then_open();
    do_reset();
    for (int f = 1; f <= 2; f++) begin
      enter_code(24'h111111);
      repeat (12) @(negedge clk);
    end
    push_exp("two_fails", pk(ALL_B, 1'b0, 1'b0, 3'd2));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    enter_code(24'h123456);
    ent = '{1, 2, 3, 4, 5, 6};
    push_exp("good_enter", pk(entry_img(), 1'b0, 1'b0, 3'd2));
    push_exp("good_check_clears_fail", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    push_exp("good_open", pk(OPEN_IMG, 1'b1, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    end
    ent.delete();
    key(4'h5);
    key(4'hA);
    push_exp("open_digit_ignored", pk(OPEN_IMG, 1'b1, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    @(negedge clk);
    push_exp("open_clear_relock", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'h8);
    ent.push_back(8);
    @(negedge clk);
    push_exp("after_open_buffer_empty", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    key(4'hA);
    ent.delete();
  endtask

  task automatic test_reset_mid_entry();
    for (int d = 1; d <= 4; d++) begin key(4'(d)); ent.push_back(d); end
    @(negedge clk);
    push_exp("mid_four_digits", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    #2 rst_n = 1'b0;
    #1;
    ent.delete();
    push_exp("async_reset_blank", pk(ALL_B, 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    key(4'h9);
    key(4'h8);
    ent.push_back(9);
    ent.push_back(8);
    @(negedge clk);
    push_exp("post_reset_count_zero", pk(entry_img(), 1'b0, 1'b0, 3'd0));
    e = sb.pop_front(); checks++;
    if (outs() !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, outs(), e.val); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_open();
    test_edit();
    test_overflow();
    test_back_to_back();
    test_short_enter();
    test_lockout();
    test_fail_then_open();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
